// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// default instruction width, default halt opcode and program counter width.
package instruction_fetch_pkg;

    // Default instruction width in bits.
    localparam int IW_DEFAULT = 16;

    // Default opcode (top nibble of the instruction) that stops fetching.
    localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

    // Program counter / memory address width.
    localparam int PC_W = 8;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } fetch_state_e;

    // Where the sequencer goes once the current fetch is finished or dropped:
    // straight back to a new request if fetching is still enabled.
    function automatic fetch_state_e after_fetch(input logic run);
        return run ? S_REQ : S_IDLE;
    endfunction

endpackage : instruction_fetch_pkg

// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer. Issues one single-cycle read per instruction at
// the PC supplied by the program counter, captures the returned word into the
// instruction register, strobes the PC increment, and holds the instruction
// until downstream acknowledges it. A PC load (flush) discards any in-flight
// read; consuming a HALT_OP instruction parks the unit until reset.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int         IW      = IW_DEFAULT,
    parameter logic [3:0] HALT_OP = HALT_OP_DEFAULT
) (
    input  logic            clk,
    input  logic            CLB,
    input  logic            run,
    input  logic [PC_W-1:0] address,
    input  logic            flush,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic [IW-1:0]   mem_rdata,
    output logic            IncPC,
    output logic [IW-1:0]   ir,
    output logic [3:0]      imm,
    output logic            ir_valid,
    input  logic            ir_ack,
    output logic            halted
);

    fetch_state_e state;

    // Set when the PC was reloaded while a read is outstanding; the data that
    // eventually comes back belongs to the old PC and must be thrown away.
    logic discard;

    // True in the WAIT cycle whose returned data is kept.
    logic take_data;

    // Request, address and increment strobe decoded from the current state.
    always_comb begin
        // NOTE: every signal gets a value before any condition so no latch is inferred.
        mem_req   = 1'b0;
        take_data = 1'b0;
        if (state == S_REQ) begin
            mem_req = 1'b1;
        end
        if (state == S_WAIT && mem_ready && !discard && !flush) begin
            take_data = 1'b1;
        end
        mem_addr = address;
        IncPC    = take_data;
        imm      = ir[3:0];
    end

    // Fetch sequencer with its registered instruction, valid, discard and halt flags.
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            state    <= S_IDLE;
            ir       <= '0;
            ir_valid <= 1'b0;
            discard  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees the pre-edge values.
            unique case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_REQ;
                    end
                end

                S_REQ: begin
                    // Any mem_ready seen here is stale; only WAIT listens to memory.
                    if (flush) begin
                        discard <= 1'b1;
                    end
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (mem_ready) begin
                        discard <= 1'b0;
                        if (take_data) begin
                            ir       <= mem_rdata;
                            ir_valid <= 1'b1;
                            state    <= S_HOLD;
                        end else begin
                            // Data belongs to a PC that has since been reloaded.
                            state <= after_fetch(run);
                        end
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (flush) begin
                        // A PC load makes the held instruction obsolete, even a halt.
                        ir_valid <= 1'b0;
                        state    <= after_fetch(run);
                    end else if (ir_ack) begin
                        ir_valid <= 1'b0;
                        if (ir[IW-1 -: 4] == HALT_OP) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            state <= after_fetch(run);
                        end
                    end
                end

                S_HALT: begin
                    // Parked until reset.
                    state <= S_HALT;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : instruction_fetch

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter IW, default 16, instruction width.
REQ-002 SHALL have parameter HALT_OP, default 4'hF, opcode that stops fetching.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 CLB  in  1  reset, asynchronous, active-high (1 = clear).
REQ-005 run  in  1  fetch enable.
REQ-006 address  in  8  current PC value from program counter.
REQ-007 flush  in  1  PC being loaded this cycle (same cycle as LoadPC); discard in-flight work.
REQ-008 mem_req  out  1  single-cycle read request.
REQ-009 mem_addr  out  8  read address, valid when mem_req=1.
REQ-010 mem_ready  in  1  read data valid, single-cycle.
REQ-011 mem_rdata  in  IW  read data.
REQ-012 IncPC  out  1  increment strobe to program counter.
REQ-013 ir  out  IW  instruction register.
REQ-014 imm  out  4  ir[3:0], feeds PC immediate load.
REQ-015 ir_valid  out  1  ir holds an unconsumed instruction.
REQ-016 ir_ack  in  1  downstream consumes ir.
REQ-017 halted  out  1  HALT_OP instruction consumed.

Function
REQ-018 SHALL implement states IDLE, REQ, WAIT, HOLD, HALT.
REQ-019 IDLE: run=1 -> REQ, else stay.
REQ-020 REQ (exactly one cycle): mem_req=1, mem_addr=address (combinational), -> WAIT; mem_ready ignored in REQ.
REQ-021 WAIT: on mem_ready with discard=0 SHALL capture mem_rdata into ir, set ir_valid, pulse IncPC=1 combinationally that cycle, -> HOLD.
REQ-022 WAIT: on mem_ready with discard=1 SHALL drop data, clear discard, no IncPC, -> REQ if run=1 else IDLE.
REQ-023 flush in REQ or WAIT (without usable mem_ready) SHALL set discard; state unchanged.
REQ-024 flush in WAIT coincident with mem_ready SHALL drop data, no IncPC, -> REQ (or IDLE if run=0).
REQ-025 HOLD: ir_valid=1; ir_ack -> clear ir_valid; if ir[IW-1:IW-4]==HALT_OP -> HALT, else -> REQ (run=1) or IDLE (run=0).
REQ-026 HOLD: flush (with or without ir_ack) SHALL clear ir_valid, -> REQ (run=1) or IDLE; HALT check not applied.
REQ-027 HALT: halted=1, mem_req=0, IncPC=0; exit only via CLB.
REQ-028 IncPC SHALL never be high when flush=1 or outside WAIT.
REQ-029 Back-to-back throughput: one instruction per 3 cycles minimum (REQ, WAIT with 1-cycle latency, HOLD with immediate ack).
REQ-030 ir SHALL hold value after ack until next capture.
REQ-031 run deasserted SHALL not abort an outstanding request; it completes and stops at IDLE.

Reset
REQ-032 CLB=1 SHALL asynchronously force state=IDLE, ir=0, ir_valid=0, discard=0, halted=0; mem_req=0, IncPC=0 while CLB=1.
REQ-033 Reset mid-WAIT SHALL abandon request; late mem_ready after reset release in IDLE ignored.

Structure
REQ-034 Shared package SHALL hold state encoding, HALT_OP default, IW default, PC width 8.
REQ-035 Single flat module; no sub-module.

Verification
REQ-036 Reset, run=1, address=8'h00, mem_ready 2 cycles after mem_req with 16'h1234 -> mem_addr=00, IncPC one pulse, ir=1234, imm=4, ir_valid until ack.
REQ-037 flush in WAIT, mem_ready next cycle with 16'hAAAA -> ir unchanged, no IncPC, new mem_req with updated address.
REQ-038 flush coincident with mem_ready -> data dropped, IncPC=0, REQ next cycle.
REQ-039 Capture 16'hF000, ack -> HALT, halted=1, no further mem_req for 20 cycles, run held high.
REQ-040 Three instructions, ack immediate, latency 1 -> mem_req every 3 cycles, exactly 3 IncPC pulses, addresses 00,01,02.
REQ-041 CLB asserted during WAIT then released, stale mem_ready arrives -> ir=0, ir_valid=0, state IDLE/REQ per run.
